// File: rtl/ts_pkg.sv
// ts_pkg: shared constants and types for the TS packet pacer slice.
//   TS_SYNC_BYTE  MPEG2-TS sync byte (0x47)
//   TS_PKT_LEN    TS packet length in bytes
//   NULL_HDR      first four bytes of a null packet (PID 0x1FFF), index 0 first
//   TS_STUFF      stuffing byte used for the null-packet payload
//   pacer_state_t pacer FSM states
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_STUFF     = 8'hFF;

  // Packed so that NULL_HDR[0] is the first byte on the wire.
  localparam logic [3:0][7:0] NULL_HDR = {8'h10, 8'hFF, 8'h1F, 8'h47};

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    STREAM,
    GAP,
    NULL
  } pacer_state_t;

endpackage

// File: rtl/ts_packet_pacer_if.sv
// ts_packet_pacer_if: TS byte stream from the pacer to the output/mux logic.
//   out_data   output byte
//   out_valid  out_data valid
//   out_sop    first byte of a packet (qualified by out_valid)
//   out_eop    last byte of a packet (qualified by out_valid)
// modport master: the pacer (drives); modport slave: the downstream consumer.
interface ts_packet_pacer_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sop;
  logic       out_eop;

  modport master (output out_data, out_valid, out_sop, out_eop);
  modport slave  (input  out_data, out_valid, out_sop, out_eop);

endinterface

// File: rtl/ts_null_gen.sv
// ts_null_gen: combinational map from byte index (0..187) to the byte of a
// null TS packet: 47 1F FF 10 followed by 0xFF stuffing.
//   idx   byte index within the packet
//   data  null-packet byte at that index
module ts_null_gen
  import ts_pkg::*;
#(
  parameter int IDX_WIDTH = 8
) (
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [7:0]           data
);

  always_comb begin
    data = TS_STUFF;
    if (idx < IDX_WIDTH'(4)) begin
      data = NULL_HDR[idx[1:0]];
    end
  end

endmodule

// File: rtl/ts_packet_pacer.sv
// ts_packet_pacer: read-side scheduler for the TS byte FIFO. Pops the FIFO,
// aligns on sync byte 0x47, emits 188-byte packets with a programmable
// inter-packet gap and inserts null packets when the FIFO runs low.
//   clk, rst                    clock, synchronous active-high reset
//   fifo_rdata/rempty/rcnt      FIFO read data (one cycle after pop), empty, level
//   fifo_ren                    FIFO pop strobe (combinational)
//   gap_cfg, null_en            gap length in cycles, null-insertion enable
//   out_if                      registered output byte stream (master)
//   pkt_cnt/null_cnt/sync_err_cnt  saturating statistics
module ts_packet_pacer
  import ts_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int PKT_LEN     = TS_PKT_LEN,
  parameter int GAP_WIDTH   = 8,
  parameter int START_LEVEL = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            fifo_rdata,
  input  logic                  fifo_rempty,
  input  logic [ADDR_WIDTH:0]   fifo_rcnt,
  output logic                  fifo_ren,
  input  logic [GAP_WIDTH-1:0]  gap_cfg,
  input  logic                  null_en,
  ts_packet_pacer_if.master     out_if,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  null_cnt,
  output logic [CNT_WIDTH-1:0]  sync_err_cnt
);

  localparam int IDX_W = $clog2(PKT_LEN + 1);

  pacer_state_t         state_reg;
  logic [IDX_W-1:0]     idx_reg;       // index of the next byte to emit
  logic [IDX_W-1:0]     pops_reg;      // pops owned by the current packet
  logic [GAP_WIDTH-1:0] gap_cnt_reg;
  logic                 expect_sync_reg;
  logic                 rd_valid_reg;  // fifo_rdata holds a freshly popped byte
  logic [7:0]           out_data_reg;
  logic                 out_valid_reg;
  logic                 out_sop_reg;
  logic                 out_eop_reg;
  logic [CNT_WIDTH-1:0] pkt_cnt_reg;
  logic [CNT_WIDTH-1:0] null_cnt_reg;
  logic [CNT_WIDTH-1:0] sync_err_cnt_reg;

  logic         start_ok;
  logic         last_idx;
  logic         hunt_drop;
  logic [7:0]   null_byte;
  pacer_state_t exit_state;
  pacer_state_t done_state;

  ts_null_gen #(.IDX_WIDTH(IDX_W)) u_null_gen (
    .idx  (idx_reg),
    .data (null_byte)
  );

  assign start_ok  = fifo_rcnt >= (ADDR_WIDTH + 1)'(START_LEVEL);
  assign last_idx  = idx_reg == IDX_W'(PKT_LEN - 1);
  assign fifo_ren  = ((state_reg == HUNT) || (state_reg == STREAM)) && !fifo_rempty &&
                     (pops_reg < IDX_W'(PKT_LEN));
  // A non-sync byte arriving while hunting is dropped and gives its pop back,
  // so pops_reg only ever counts bytes that belong to the packet.
  assign hunt_drop = (state_reg == HUNT) && rd_valid_reg && (fifo_rdata != TS_SYNC_BYTE);

  // Shared IDLE/GAP exit decision; a real packet wins over a null packet.
  assign exit_state = start_ok ? HUNT : (null_en ? NULL : IDLE);
  // With a zero gap the exit decision is taken on the eop cycle itself.
  assign done_state = (gap_cfg == '0) ? exit_state : GAP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      pops_reg         <= '0;
      gap_cnt_reg      <= '0;
      expect_sync_reg  <= 1'b0;
      rd_valid_reg     <= 1'b0;
      out_data_reg     <= '0;
      out_valid_reg    <= 1'b0;
      out_sop_reg      <= 1'b0;
      out_eop_reg      <= 1'b0;
      pkt_cnt_reg      <= '0;
      null_cnt_reg     <= '0;
      sync_err_cnt_reg <= '0;
    end else begin
      rd_valid_reg  <= fifo_ren;
      out_valid_reg <= 1'b0;
      out_sop_reg   <= 1'b0;
      out_eop_reg   <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          state_reg       <= exit_state;
          expect_sync_reg <= 1'b1;
          idx_reg         <= '0;
          pops_reg        <= '0;
        end
        HUNT: begin
          pops_reg <= pops_reg + IDX_W'(fifo_ren) - IDX_W'(hunt_drop);
          if (rd_valid_reg) begin
            expect_sync_reg <= 1'b0;
            if (fifo_rdata == TS_SYNC_BYTE) begin
              out_valid_reg <= 1'b1;
              out_sop_reg   <= 1'b1;
              out_data_reg  <= fifo_rdata;
              idx_reg       <= IDX_W'(1);
              state_reg     <= STREAM;
            end else if (expect_sync_reg && (sync_err_cnt_reg != '1)) begin
              sync_err_cnt_reg <= sync_err_cnt_reg + CNT_WIDTH'(1);
            end
          end
        end
        STREAM: begin
          pops_reg <= pops_reg + IDX_W'(fifo_ren);
          // No byte arriving means the FIFO ran dry: hold the index and stall.
          if (rd_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= fifo_rdata;
            out_eop_reg   <= last_idx;
            idx_reg       <= idx_reg + IDX_W'(1);
            if (last_idx) begin
              if (pkt_cnt_reg != '1) pkt_cnt_reg <= pkt_cnt_reg + CNT_WIDTH'(1);
              state_reg       <= done_state;
              gap_cnt_reg     <= gap_cfg;
              expect_sync_reg <= 1'b1;
              idx_reg         <= '0;
              pops_reg        <= '0;
            end
          end
        end
        NULL: begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= null_byte;
          out_sop_reg   <= (idx_reg == '0);
          out_eop_reg   <= last_idx;
          idx_reg       <= idx_reg + IDX_W'(1);
          if (last_idx) begin
            if (null_cnt_reg != '1) null_cnt_reg <= null_cnt_reg + CNT_WIDTH'(1);
            state_reg       <= done_state;
            gap_cnt_reg     <= gap_cfg;
            expect_sync_reg <= 1'b1;
            idx_reg         <= '0;
            pops_reg        <= '0;
          end
        end
        GAP: begin
          if (gap_cnt_reg <= GAP_WIDTH'(1)) begin
            state_reg       <= exit_state;
            expect_sync_reg <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_WIDTH'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_if.out_data  = out_data_reg;
  assign out_if.out_valid = out_valid_reg;
  assign out_if.out_sop   = out_sop_reg;
  assign out_if.out_eop   = out_eop_reg;
  assign pkt_cnt          = pkt_cnt_reg;
  assign null_cnt         = null_cnt_reg;
  assign sync_err_cnt     = sync_err_cnt_reg;

endmodule

// File: doc/ts_packet_pacer.md
Name: ts_packet_pacer

Overview:
Read-side scheduler for the TS byte FIFO. It sequences FIFO pops and aligns the byte stream to 188-byte MPEG2-TS packets on sync byte 0x47. It paces packets with a programmable inter-packet gap and can insert null packets (PID 0x1FFF) when too few bytes are buffered, which keeps the output packet rate constant for downstream QoS shaping. It sits between the async FIFO read port and the TS output/mux logic in the 100 MHz domain.

Parameters:
ADDR_WIDTH, 4, FIFO address width; fifo_rcnt is ADDR_WIDTH+1 bits.
PKT_LEN, 188, TS packet length in bytes.
GAP_WIDTH, 8, width of gap_cfg.
START_LEVEL, 8, minimum fifo_rcnt required to start a real packet from IDLE or GAP.
CNT_WIDTH, 16, width of the statistics counters.

Ports:
clk  in  1  single clock for the block (FIFO read clock).
rst  in  1  synchronous reset, active high.
fifo_rdata  in  8  FIFO read data; valid the cycle after a pop.
fifo_rempty  in  1  FIFO empty flag.
fifo_rcnt  in  ADDR_WIDTH+1  FIFO fill level.
fifo_ren  out  1  pop strobe (combinational).
gap_cfg  in  GAP_WIDTH  idle cycles inserted between packets.
null_en  in  1  enables null-packet insertion.
out_data  out  8  output byte.
out_valid  out  1  out_data valid.
out_sop  out  1  first byte of a packet, qualified by out_valid.
out_eop  out  1  last byte of a packet, qualified by out_valid.
pkt_cnt  out  CNT_WIDTH  real packets emitted; saturating.
null_cnt  out  CNT_WIDTH  null packets emitted; saturating.
sync_err_cnt  out  CNT_WIDTH  expected-sync misses; saturating.

Behaviour:
- Reset (sync, rst=1): state=IDLE; all counters 0; out_valid, out_sop, out_eop = 0; out_data = 0; fifo_ren = 0; byte index = 0.
- fifo_ren = (state in HUNT/STREAM) && !fifo_rempty && (pops_this_pkt < PKT_LEN). A pop is never issued while the FIFO is empty.
- Latency: a byte popped at cycle t is on fifo_rdata at t+1 and on out_data with out_valid=1 at t+2. All outputs are registered.
- IDLE: if fifo_rcnt >= START_LEVEL, go to HUNT with expect_sync=1. Otherwise, if null_en=1, go to NULL.
- HUNT: pop while data is available and check each arriving byte.
  - A byte != 0x47 is discarded, with no output.
  - If expect_sync=1 and the first arriving byte is != 0x47, increment sync_err_cnt once and clear expect_sync.
  - When 0x47 arrives, that byte becomes byte 0. Bytes popped speculatively after it become bytes 1.., so no byte is lost or duplicated. Go to STREAM.
- STREAM: emit PKT_LEN bytes. out_sop=1 on byte 0 and out_eop=1 on byte PKT_LEN-1.
  - If the FIFO is empty mid-packet, stall: out_valid=0 and the index holds. The packet resumes without loss.
  - After the eop byte, increment pkt_cnt and go to GAP. If gap_cfg=0, skip GAP and apply the GAP exit decision immediately.
- GAP: count gap_cfg cycles with out_valid=0, then:
  - if fifo_rcnt >= START_LEVEL, go to HUNT with expect_sync=1;
  - else if null_en=1, go to NULL;
  - else go to IDLE.
- NULL: emit 188 bytes, one per cycle with no stall: 0x47, 0x1F, 0xFF, 0x10, then 184 x 0xFF. sop/eop as in STREAM. Then increment null_cnt and go to GAP. The FIFO is not popped.
- A null packet in progress is never preempted by FIFO data; a real packet starts only at a packet boundary.
- Counters saturate at all-ones.
- null_en and gap_cfg are sampled at decision points only: the IDLE/GAP exit and the GAP load.
- rst asserted mid-packet aborts immediately. No eop is emitted and the statistics reset. FIFO contents are the FIFO's own concern.

Decomposition:
- Package ts_pkg holds TS_SYNC_BYTE=8'h47, TS_PKT_LEN=188, NULL_HDR bytes {47,1F,FF,10}, TS_STUFF=8'hFF, and the pacer state enum {IDLE,HUNT,STREAM,GAP,NULL}.
- One sub-module, ts_null_gen: maps a byte index (0..187) to a null-packet byte. It is purely combinational and shared with future mux blocks.

Test Plan:
- Aligned packet: preload 188 bytes starting 0x47, gap_cfg=4, null_en=0 -> 188 contiguous out_valid, sop on 0x47, eop on byte 187; pkt_cnt=1; 4 idle cycles; then IDLE.
- Misaligned: 5 junk bytes (0x00) then a packet -> junk dropped, sync_err_cnt=1, packet emitted intact, pkt_cnt=1.
- Starvation: supply 100 bytes, pause 20 cycles, supply 88 -> out_valid drops for the stall; 188 bytes total, single eop, no sync error.
- Null insertion: null_en=1, empty FIFO, gap_cfg=2 -> back-to-back null packets 47 1F FF 10 FF..., 2-cycle gaps, null_cnt increments per packet, fifo_ren never 1.
- Boundary handoff: during a null packet, raise fifo_rcnt to START_LEVEL -> the null packet completes, then after the gap a real packet starts. gap_cfg=0 -> the next sop comes the cycle after eop for NULL, or at the 2-cycle pop latency for real data.
- Reset mid-STREAM at byte 50 -> the next cycle has out_valid=0, all counters 0, state IDLE; a later aligned packet is emitted correctly.
